// File: rtl/lv_owt_tx_ctrl_if.sv
// Request/status bundle between the LV register/ADC logic (master) and the OWT transmitter (slave).
// Carries the frame request, its cmd/data payload, and busy/ack/line status back from the transmitter.
interface lv_owt_tx_ctrl_if #(
  parameter int OWT_CMD_BIT_NUM  = 8,
  parameter int OWT_ADCD_BIT_NUM = 10
) ();
  logic                        i_owt_tx_req;
  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd;
  logic [OWT_ADCD_BIT_NUM-1:0] i_owt_tx_data;
  logic                        o_owt_tx_busy;
  logic                        o_owt_tx_ack;
  logic                        o_lv_hv_owt_tx;

  modport master (
    output i_owt_tx_req, i_owt_tx_cmd, i_owt_tx_data,
    input  o_owt_tx_busy, o_owt_tx_ack, o_lv_hv_owt_tx
  );

  modport slave (
    input  i_owt_tx_req, i_owt_tx_cmd, i_owt_tx_data,
    output o_owt_tx_busy, o_owt_tx_ack, o_lv_hv_owt_tx
  );
endinterface

// File: rtl/lv_owt_tx_ctrl.sv
// OWT transmitter: serialises one cmd/data word as a Manchester frame; line starts the cycle after acceptance.
// Requests are sampled only in IDLE; requests while busy are dropped, not queued.
module lv_owt_tx_ctrl #(
  parameter int OWT_EXT_CYC_NUM  = 8,
  parameter int OWT_SYNC_BIT_NUM = 12,
  parameter int OWT_TAIL_BIT_NUM = 4,
  parameter int OWT_CMD_BIT_NUM  = 8,
  parameter int OWT_DATA_BIT_NUM = 8,
  parameter int OWT_ADCD_BIT_NUM = 10,
  parameter int OWT_CRC_BIT_NUM  = 8,
  parameter int OWT_GAP_CHIP_NUM = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  lv_owt_tx_ctrl_if.slave owt
);
  typedef enum logic [2:0] {
    IDLE, SYNC_HEAD, SYNC_TAIL, CMD, DATA, CRC, END_TAIL, GAP
  } state_t;

  localparam int CHIP_W = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
  localparam int BIT_W  = 8;
  localparam logic [BIT_W-1:0]           DATA_SH  = BIT_W'(OWT_ADCD_BIT_NUM - OWT_DATA_BIT_NUM);
  localparam logic [OWT_CRC_BIT_NUM-1:0] CRC_POLY = OWT_CRC_BIT_NUM'('h07);

  state_t                      state_q, state_d, next_field;
  logic [CHIP_W-1:0]           chip_cnt, chip_d;
  logic                        half_q, half_d;
  logic [BIT_W-1:0]            bit_cnt, bit_d, field_len;
  logic [OWT_CMD_BIT_NUM-1:0]  cmd_q;
  logic [OWT_ADCD_BIT_NUM-1:0] data_q;
  logic                        adc_len_q;
  logic [OWT_CRC_BIT_NUM-1:0]  crc_q, crc_next;
  logic                        line_q, line_d;
  logic                        chip_end, manch, sym_step, field_last, crc_in, crc_upd, accept;

  // Bit b (MSB first) of the Manchester field s; left-justify the field and take its top bit.
  function automatic logic sym_bit(input state_t s, input logic [BIT_W-1:0] b);
    logic [OWT_CMD_BIT_NUM-1:0]  c;
    logic [OWT_ADCD_BIT_NUM-1:0] d;
    logic [OWT_CRC_BIT_NUM-1:0]  r;
    logic [BIT_W-1:0]            sh;
    sh = adc_len_q ? b : b + DATA_SH;
    c  = cmd_q << b;
    d  = data_q << sh;
    r  = crc_q << b;
    case (s)
      CMD:     return c[OWT_CMD_BIT_NUM-1];
      DATA:    return d[OWT_ADCD_BIT_NUM-1];
      CRC:     return r[OWT_CRC_BIT_NUM-1];
      default: return 1'b0;
    endcase
  endfunction

  assign chip_end   = (chip_cnt == CHIP_W'(OWT_EXT_CYC_NUM - 1));
  assign sym_step   = chip_end & (half_q | ~manch);
  assign field_last = (bit_cnt == field_len - 1'b1);
  assign accept     = (state_q == IDLE) && owt.i_owt_tx_req;

  always_comb begin
    field_len  = '0;
    next_field = IDLE;
    manch      = 1'b0;
    case (state_q)
      SYNC_HEAD: begin field_len = BIT_W'(OWT_SYNC_BIT_NUM); next_field = SYNC_TAIL; manch = 1'b1; end
      SYNC_TAIL: begin field_len = BIT_W'(OWT_TAIL_BIT_NUM); next_field = CMD;                      end
      CMD:       begin field_len = BIT_W'(OWT_CMD_BIT_NUM);  next_field = DATA;      manch = 1'b1; end
      DATA: begin
        field_len  = adc_len_q ? BIT_W'(OWT_ADCD_BIT_NUM) : BIT_W'(OWT_DATA_BIT_NUM);
        next_field = CRC;
        manch      = 1'b1;
      end
      CRC:       begin field_len = BIT_W'(OWT_CRC_BIT_NUM);  next_field = END_TAIL;  manch = 1'b1; end
      END_TAIL:  begin field_len = BIT_W'(OWT_TAIL_BIT_NUM); next_field = GAP;                      end
      GAP:       begin field_len = BIT_W'(OWT_GAP_CHIP_NUM); next_field = IDLE;                     end
      default:   ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    chip_d  = chip_cnt;
    half_d  = half_q;
    bit_d   = bit_cnt;
    case (state_q)
      IDLE: if (owt.i_owt_tx_req) state_d = SYNC_HEAD;
      SYNC_HEAD, SYNC_TAIL, CMD, DATA, CRC, END_TAIL, GAP: begin
        chip_d = chip_end ? '0 : chip_cnt + 1'b1;
        half_d = half_q ^ chip_end;
        if (sym_step) begin
          if (field_last) begin
            state_d = next_field;
            bit_d   = '0;
            half_d  = 1'b0;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        chip_d  = '0;
        half_d  = 1'b0;
        bit_d   = '0;
      end
    endcase
  end

  // Line is registered from next-cycle state so each chip level lands exactly on its first cycle.
  always_comb begin
    line_d = 1'b0;
    case (state_d)
      SYNC_HEAD, CMD, DATA, CRC: line_d = ~(sym_bit(state_d, bit_d) ^ half_d);
      SYNC_TAIL, END_TAIL:       line_d = (bit_d < BIT_W'(OWT_TAIL_BIT_NUM / 2));
      default:                   line_d = 1'b0;
    endcase
  end

  assign crc_in   = sym_bit(state_q, bit_cnt);
  assign crc_upd  = ((state_q == CMD) || (state_q == DATA)) && (chip_cnt == '0) && !half_q;
  assign crc_next = {crc_q[OWT_CRC_BIT_NUM-2:0], 1'b0} ^
                    ((crc_q[OWT_CRC_BIT_NUM-1] ^ crc_in) ? CRC_POLY : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      chip_cnt  <= '0;
      half_q    <= 1'b0;
      bit_cnt   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      adc_len_q <= 1'b0;
      crc_q     <= '0;
      line_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chip_cnt <= chip_d;
      half_q   <= half_d;
      bit_cnt  <= bit_d;
      line_q   <= line_d;
      if (accept) begin
        cmd_q     <= owt.i_owt_tx_cmd;
        data_q    <= owt.i_owt_tx_data;
        adc_len_q <= !owt.i_owt_tx_cmd[OWT_CMD_BIT_NUM-1] &&
                     (owt.i_owt_tx_cmd[OWT_CMD_BIT_NUM-2:0] == (OWT_CMD_BIT_NUM-1)'('h1f));
        crc_q     <= '0;
      end else if (crc_upd) begin
        crc_q <= crc_next;
      end
    end
  end

  assign owt.o_lv_hv_owt_tx = line_q;
  assign owt.o_owt_tx_busy  = (state_q != IDLE);
  assign owt.o_owt_tx_ack   = (state_q == GAP) && chip_end && field_last;
endmodule

// File: tb/tb_lv_owt_tx_ctrl.sv
// Bench for lv_owt_tx_ctrl: a default-timing instance and a 2-cycle-chip instance, checked against a
// chip-list frame model and a behavioural receiver.
module tb_lv_owt_tx_ctrl;
  logic       clk;
  logic       rst;
  logic       req_v  [2];
  logic [7:0] cmd_v  [2];
  logic [9:0] data_v [2];
  logic       busy_o [2];
  logic       ack_o  [2];
  logic       line_o [2];

  int checks = 0;
  int errors = 0;
  int ack_cnt [2] = '{0, 0};

  logic       wave [0:2047];
  logic       exp_q [$];
  logic       msg_q [$];
  int         rx_st;
  logic [7:0] rx_cmd;
  logic [9:0] rx_data;
  logic [7:0] rx_crc;

  lv_owt_tx_ctrl_if #(.OWT_CMD_BIT_NUM(8), .OWT_ADCD_BIT_NUM(10)) if0 ();
  lv_owt_tx_ctrl_if #(.OWT_CMD_BIT_NUM(8), .OWT_ADCD_BIT_NUM(10)) if1 ();

  lv_owt_tx_ctrl u_dut0 (.i_clk(clk), .i_rst(rst), .owt(if0));
  lv_owt_tx_ctrl #(.OWT_EXT_CYC_NUM(2)) u_dut1 (.i_clk(clk), .i_rst(rst), .owt(if1));

  assign if0.i_owt_tx_req  = req_v[0];
  assign if0.i_owt_tx_cmd  = cmd_v[0];
  assign if0.i_owt_tx_data = data_v[0];
  assign if1.i_owt_tx_req  = req_v[1];
  assign if1.i_owt_tx_cmd  = cmd_v[1];
  assign if1.i_owt_tx_data = data_v[1];
  assign busy_o[0] = if0.o_owt_tx_busy;
  assign ack_o[0]  = if0.o_owt_tx_ack;
  assign line_o[0] = if0.o_lv_hv_owt_tx;
  assign busy_o[1] = if1.o_owt_tx_busy;
  assign ack_o[1]  = if1.o_owt_tx_ack;
  assign line_o[1] = if1.o_lv_hv_owt_tx;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack_o[0] === 1'b1) ack_cnt[0] <= ack_cnt[0] + 1;
    if (ack_o[1] === 1'b1) ack_cnt[1] <= ack_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int dlen(input logic [7:0] c);
    return (c[7] == 1'b0 && c[6:0] == 7'h1f) ? 10 : 8;
  endfunction

  // CRC as the remainder of msg(x)*x^8 divided by x^8+x^2+x+1 (polynomial long division).
  function automatic logic [7:0] crc_div(input logic msg [$]);
    logic       m [$];
    logic [8:0] g;
    logic [7:0] r;
    g = 9'h107;
    m = msg;
    for (int i = 0; i < 8; i++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ g[8-j];
    for (int i = 0; i < 8; i++) r[7-i] = m[msg.size()+i];
    return r;
  endfunction

  task automatic build_frame(input logic [7:0] c, input logic [9:0] d);
    logic [7:0] r;
    msg_q.delete();
    exp_q.delete();
    for (int i = 7; i >= 0; i--) msg_q.push_back(c[i]);
    for (int i = dlen(c) - 1; i >= 0; i--) msg_q.push_back(d[i]);
    r = crc_div(msg_q);
    for (int i = 0; i < 12; i++) begin exp_q.push_back(1'b1); exp_q.push_back(1'b0); end
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    foreach (msg_q[i]) begin exp_q.push_back(~msg_q[i]); exp_q.push_back(msg_q[i]); end
    for (int i = 7; i >= 0; i--) begin exp_q.push_back(~r[i]); exp_q.push_back(r[i]); end
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
  endtask

  function automatic logic ch(input int ext, input int j);
    return wave[j*ext + ext/2 + 1];
  endfunction

  // Behavioural receiver: mid-chip sampling, structural checks, then CRC verification.
  task automatic rx_decode(input int ext);
    int   j;
    logic a, b;
    logic bits [$];
    j = 0; rx_st = 0; rx_cmd = '0; rx_data = '0; rx_crc = '0;
    for (int i = 0; i < 12; i++) begin
      if (ch(ext, j) !== 1'b1 || ch(ext, j+1) !== 1'b0) rx_st = 1;
      j += 2;
    end
    for (int i = 0; i < 4; i++) begin
      if (ch(ext, j) !== ((i < 2) ? 1'b1 : 1'b0)) rx_st = 1;
      j++;
    end
    for (int i = 7; i >= 0; i--) begin
      a = ch(ext, j); b = ch(ext, j+1); j += 2;
      if (a !== ~b) rx_st = 1;
      rx_cmd[i] = b; bits.push_back(b);
    end
    for (int i = dlen(rx_cmd) - 1; i >= 0; i--) begin
      a = ch(ext, j); b = ch(ext, j+1); j += 2;
      if (a !== ~b) rx_st = 1;
      rx_data[i] = b; bits.push_back(b);
    end
    for (int i = 7; i >= 0; i--) begin
      a = ch(ext, j); b = ch(ext, j+1); j += 2;
      if (a !== ~b) rx_st = 1;
      rx_crc[i] = b;
    end
    for (int i = 0; i < 4; i++) begin
      if (ch(ext, j) !== ((i < 2) ? 1'b1 : 1'b0)) rx_st = 1;
      j++;
    end
    for (int i = 0; i < 4; i++) begin
      if (ch(ext, j) !== 1'b0) rx_st = 1;
      j++;
    end
    if (rx_st == 0 && crc_div(bits) !== rx_crc) rx_st = 2;
  endtask

  // Drive a one-cycle request from idle; afterwards scramble inputs so frozen shadows are exercised.
  task automatic start(input int d, input string tag, input logic [7:0] c, input logic [9:0] dt);
    req_v[d] = 1'b1; cmd_v[d] = c; data_v[d] = dt;
    @(posedge clk); #1;
    req_v[d] = 1'b0; cmd_v[d] = 8'($urandom); data_v[d] = 10'($urandom);
    chk({tag, "/busy_rise"}, busy_o[d], 1'b1);
    chk({tag, "/first_chip"}, line_o[d], 1'b1);
  endtask

  // Record the line from frame cycle 1 until ack (bounded); optionally re-request mid-frame.
  task automatic collect(input int d, input int mid_k, output int ack_k);
    ack_k = -1;
    foreach (wave[i]) wave[i] = 1'bx;
    for (int k = 1; k < 2000; k++) begin
      wave[k] = line_o[d];
      if (mid_k > 0 && k == mid_k) begin req_v[d] = 1'b1; cmd_v[d] = 8'h02; data_v[d] = 10'h0c3; end
      if (mid_k > 0 && k == mid_k + 40) begin cmd_v[d] = 8'h1f; data_v[d] = 10'h155; end
      if (ack_o[d] === 1'b1) begin ack_k = k; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input int d, input string tag, input logic [7:0] c, input logic [9:0] dt,
                             input int ack_k);
    int         ext, len, bad;
    logic [9:0] dexp;
    ext = (d == 0) ? 8 : 2;
    build_frame(c, dt);
    len = exp_q.size() * ext;
    chk({tag, "/ack_cycle"}, ack_k, len);
    bad = 0;
    for (int k = 1; k <= len; k++) if (wave[k] !== exp_q[(k-1)/ext]) bad++;
    chk({tag, "/wave_errs"}, bad, 0);
    rx_decode(ext);
    dexp = (dlen(c) == 10) ? dt : {2'b00, dt[7:0]};
    chk({tag, "/rx_status"}, rx_st, 0);
    chk({tag, "/rx_cmd"}, rx_cmd, c);
    chk({tag, "/rx_data"}, rx_data, dexp);
  endtask

  task automatic after_frame(input int d, input string tag);
    @(posedge clk); #1;
    chk({tag, "/busy_fall"}, busy_o[d], 1'b0);
    chk({tag, "/ack_single"}, ack_o[d], 1'b0);
  endtask

  initial begin
    int         ak, a0, n1, bad;
    logic [7:0] c;
    logic [9:0] dt;
    clk = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin req_v[d] = 1'b0; cmd_v[d] = '0; data_v[d] = '0; end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset/busy", busy_o[d], 1'b0);
      chk("reset/ack", ack_o[d], 1'b0);
      chk("reset/line", line_o[d], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    start(0, "wr", 8'h81, 10'h05a);
    collect(0, -1, ak);
    check_frame(0, "wr", 8'h81, 10'h05a, ak);
    chk("wr/len672", ak, 672);
    chk("wr/crc", rx_crc, 8'h22);
    after_frame(0, "wr");

    start(0, "adc", 8'h1f, 10'h2a5);
    collect(0, -1, ak);
    check_frame(0, "adc", 8'h1f, 10'h2a5, ak);
    chk("adc/len704", ak, 704);
    chk("adc/data10", rx_data, 10'h2a5);
    after_frame(0, "adc");

    start(0, "busy", 8'h81, 10'h05a);
    collect(0, 100, ak);
    check_frame(0, "busy", 8'h81, 10'h05a, ak);
    @(posedge clk); #1;
    chk("busy/fall", busy_o[0], 1'b0);
    chk("busy/ack_off", ack_o[0], 1'b0);
    @(posedge clk); #1;
    chk("busy/restart", busy_o[0], 1'b1);
    chk("busy/restart_line", line_o[0], 1'b1);
    req_v[0] = 1'b0;
    collect(0, -1, ak);
    check_frame(0, "busy2", 8'h1f, 10'h155, ak);
    after_frame(0, "busy2");

    start(0, "rst", 8'h81, 10'h05a);
    repeat (249) begin @(posedge clk); #1; end
    a0 = ack_cnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst/line", line_o[0], 1'b0);
    chk("rst/busy", busy_o[0], 1'b0);
    chk("rst/ack", ack_o[0], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (800) begin @(posedge clk); #1; end
    chk("rst/no_ack", ack_cnt[0], a0);
    start(0, "post_rst", 8'h3c, 10'h0e7);
    collect(0, -1, ak);
    check_frame(0, "post_rst", 8'h3c, 10'h0e7, ak);
    after_frame(0, "post_rst");

    start(1, "min", 8'h81, 10'h05a);
    collect(1, -1, ak);
    check_frame(1, "min", 8'h81, 10'h05a, ak);
    chk("min/len168", ak, 168);
    bad = 0;
    for (int k = 2; k <= ak && k < 2048; k++) if (wave[k] !== wave[k-1] && ((k - 1) % 2) != 0) bad++;
    chk("min/odd_edges", bad, 0);
    after_frame(1, "min");

    n1 = ack_cnt[1];
    for (int f = 0; f < 200; f++) begin
      c  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) c = 8'h1f;
      dt = 10'($urandom);
      start(1, "lb", c, dt);
      collect(1, -1, ak);
      check_frame(1, "lb", c, dt, ak);
      after_frame(1, "lb");
    end
    chk("lb/ack_count", ack_cnt[1] - n1, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
